// File: rtl/ivb_assembler_if.sv
// Write-beat and read-word handshake bundle for ivb_assembler.
// The producer/consumer side uses master; the assembler uses slave.
interface ivb_assembler_if #(
    parameter int IN_W  = 128,
    parameter int BEATS = 2,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                    wen;
    logic                    wlast;
    logic [IN_W-1:0]         wdata;
    logic                    wready;
    logic                    rvalid;
    logic [IN_W*BEATS-1:0]   rdata;
    logic                    rlast;
    logic                    rready;
    logic [CW-1:0]           count;

    modport master (output wen, wlast, wdata, rready,
                    input  wready, rvalid, rdata, rlast, count);
    modport slave  (input  wen, wlast, wdata, rready,
                    output wready, rvalid, rdata, rlast, count);
endinterface

// File: rtl/ivb_assembler.sv
// Packs BEATS write beats (first beat in the top slice) into one word and
// queues finished words in a first-word-fall-through FIFO.
module ivb_assembler #(
    parameter int IN_W  = 128,
    parameter int BEATS = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    ivb_assembler_if.slave   bus
);
    localparam int W  = IN_W * BEATS;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [W-1:0]  asm_q, asm_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [W-1:0]     fifo_mem [DEPTH];
    logic [DEPTH-1:0] fifo_last;

    logic         accept;
    logic         push;
    logic         pop;
    logic [W-1:0] word;

    // Unwritten slices are already zero because asm_q clears on every push,
    // so OR-ing in the current beat also performs the partial-word padding.
    always_comb begin
        accept   = bus.wen && bus.wready;
        word     = asm_q | (W'(bus.wdata) << (IN_W * (BEATS - 1 - int'(bcnt_q))));
        push     = accept && ((bcnt_q == BW'(BEATS - 1)) || bus.wlast);
        pop      = bus.rvalid && bus.rready;
        bcnt_d   = bcnt_q;
        asm_d    = asm_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (accept) begin
            if (push) begin
                bcnt_d = '0;
                asm_d  = '0;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
                asm_d  = word;
            end
        end
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt_q   <= '0;
            asm_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            bcnt_q   <= bcnt_d;
            asm_q    <= asm_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage only; visibility is governed by count_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q]  <= word;
            fifo_last[wr_ptr_q] <= bus.wlast;
        end
    end

    assign bus.wready = (count_q != CW'(DEPTH));
    assign bus.rvalid = (count_q != '0);
    assign bus.count  = count_q;
    assign bus.rdata  = bus.rvalid ? fifo_mem[rd_ptr_q] : '0;
    assign bus.rlast  = bus.rvalid && fifo_last[rd_ptr_q];
endmodule

// File: tb/tb_ivb_assembler.sv
// Scoreboard bench: stimulus pushes expected words, per-DUT monitors pop and compare.
module tb_ivb_assembler;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ivb_assembler_if #(.IN_W(128), .BEATS(2), .DEPTH(DEPTH)) a ();
    ivb_assembler_if #(.IN_W(32),  .BEATS(4), .DEPTH(DEPTH)) b ();

    ivb_assembler #(.IN_W(128), .BEATS(2), .DEPTH(DEPTH)) u_a (
        .clk(clk), .reset(reset), .bus(a.slave));
    ivb_assembler #(.IN_W(32), .BEATS(4), .DEPTH(DEPTH)) u_b (
        .clk(clk), .reset(reset), .bus(b.slave));

    typedef struct packed { logic [255:0] data; logic last; } exp_a_t;
    typedef struct packed { logic [127:0] data; logic last; } exp_b_t;

    exp_a_t qa[$];
    exp_b_t qb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     cnt_chk = 1'b0;
    bit     done;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && a.rvalid && a.rready) begin
            if (qa.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL a_unexpected_word: got %h expected none", a.rdata);
            end else begin
                exp_a_t e;
                e = qa.pop_front();
                check("a_rdata", a.rdata, e.data);
                check("a_rlast", a.rlast, e.last);
            end
        end
        if (reset && cnt_chk) check("a_count_le_depth", a.count <= 3'(DEPTH), 1);
    end

    always @(negedge clk) begin
        if (reset && b.rvalid && b.rready) begin
            if (qb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL b_unexpected_word: got %h expected none", b.rdata);
            end else begin
                exp_b_t e;
                e = qb.pop_front();
                check("b_rdata", b.rdata, e.data);
                check("b_rlast", b.rlast, e.last);
            end
        end
    end

    task automatic send_a(input logic [127:0] d, input logic l);
        int n = 0;
        a.wen = 1'b1; a.wdata = d; a.wlast = l;
        @(negedge clk);
        while (!a.wready && n < 200) begin @(negedge clk); n++; end
        if (!a.wready) begin
            n_tests++; n_fail++;
            $display("FAIL a_send_timeout: got wready=0 expected 1");
        end
        @(posedge clk); #1;
        a.wen = 1'b0; a.wlast = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic l);
        int n = 0;
        b.wen = 1'b1; b.wdata = d; b.wlast = l;
        @(negedge clk);
        while (!b.wready && n < 200) begin @(negedge clk); n++; end
        if (!b.wready) begin
            n_tests++; n_fail++;
            $display("FAIL b_send_timeout: got wready=0 expected 1");
        end
        @(posedge clk); #1;
        b.wen = 1'b0; b.wlast = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        a.rready = 1'b1;
        @(negedge clk);
        while (a.count != 0 && n < 200) begin @(negedge clk); n++; end
        check("a_drained_count", a.count, 0);
        @(posedge clk); #1;
        a.rready = 1'b0;
    endtask

    initial begin
        logic [127:0] d1, d2;
        reset = 1'b0;
        a.wen = 0; a.wlast = 0; a.wdata = '0; a.rready = 0;
        b.wen = 0; b.wlast = 0; b.wdata = '0; b.rready = 0;
        #2;
        check("rst_a_rvalid", a.rvalid, 0);
        check("rst_a_rlast",  a.rlast, 0);
        check("rst_a_rdata",  a.rdata, 0);
        check("rst_a_wready", a.wready, 1);
        check("rst_a_count",  a.count, 0);
        check("rst_b_wready", b.wready, 1);
        check("rst_b_rdata",  b.rdata, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Two-beat word, immediate consumer
        a.rready = 1'b1;
        qa.push_back({128'hA, 128'hB, 1'b0});
        send_a(128'hA, 1'b0);
        check("lat_rvalid_after_1st", a.rvalid, 0);
        send_a(128'hB, 1'b0);
        check("lat_rvalid", a.rvalid, 1);
        check("lat_count", a.count, 1);
        @(posedge clk); #1;
        check("lat_count_back0", a.count, 0);
        a.rready = 1'b0;

        // Partial flush on the 4-beat instance
        b.rready = 1'b1;
        qb.push_back({128'h00000011_00000022_00000000_00000000, 1'b1});
        send_b(32'h11, 1'b0);
        send_b(32'h22, 1'b1);
        check("flush_rvalid", b.rvalid, 1);
        check("flush_bcnt", u_b.bcnt_q, 0);
        @(posedge clk); #1;
        check("flush_count", b.count, 0);
        b.rready = 1'b0;

        // Backpressure: 10 beats into a stalled FIFO
        for (int k = 0; k < 4; k++) begin
            qa.push_back({128'(2*k+1), 128'(2*k+2), 1'b0});
            send_a(128'(2*k+1), 1'b0);
            send_a(128'(2*k+2), 1'b0);
        end
        check("bp_full_count", a.count, 4);
        check("bp_full_wready", a.wready, 0);
        a.wen = 1'b1; a.wdata = 128'd9; a.wlast = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("bp_held_count", a.count, 4);
        check("bp_held_bcnt", u_a.bcnt_q, 0);
        a.rready = 1'b1;
        @(posedge clk); #1;
        a.rready = 1'b0;
        check("bp_pop_count", a.count, 3);
        check("bp_pop_wready", a.wready, 1);
        check("bp_9th_not_yet", u_a.bcnt_q, 0);
        @(posedge clk); #1;
        a.wen = 1'b0;
        check("bp_9th_taken", u_a.bcnt_q, 1);
        qa.push_back({128'd9, 128'd10, 1'b0});
        send_a(128'd10, 1'b0);
        check("bp_refill_count", a.count, 4);
        drain_a();

        // Push and pop on the same edge with two words queued
        qa.push_back({128'h21, 128'h22, 1'b0});
        qa.push_back({128'h31, 128'h32, 1'b1});
        qa.push_back({128'h41, 128'h42, 1'b0});
        send_a(128'h21, 1'b0);
        send_a(128'h22, 1'b0);
        send_a(128'h31, 1'b0);
        send_a(128'h32, 1'b1);
        check("pp_pre_count", a.count, 2);
        send_a(128'h41, 1'b0);
        a.rready = 1'b1; a.wen = 1'b1; a.wdata = 128'h42;
        @(posedge clk); #1;
        a.rready = 1'b0; a.wen = 1'b0;
        check("pp_count", a.count, 2);
        check("pp_head", a.rdata, {128'h31, 128'h32});
        check("pp_head_last", a.rlast, 1);
        drain_a();

        // Asynchronous reset mid-word
        send_a(128'hDEAD, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_wready", a.wready, 1);
        check("mid_rst_rvalid", a.rvalid, 0);
        check("mid_rst_count",  a.count, 0);
        check("mid_rst_rdata",  a.rdata, 0);
        check("mid_rst_bcnt",   u_a.bcnt_q, 0);
        #1 reset = 1'b1;
        a.rready = 1'b1;
        qa.push_back({128'h51, 128'h52, 1'b0});
        send_a(128'h51, 1'b0);
        send_a(128'h52, 1'b0);
        drain_a();

        // Wrap-around with random consumer stalls
        cnt_chk = 1'b1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * DEPTH; i++) begin
                    d1 = 128'h1000 + 128'(2*i);
                    d2 = 128'h1000 + 128'(2*i+1);
                    if (i % 3 == 2) begin
                        qa.push_back({d1, 128'h0, 1'b1});
                        send_a(d1, 1'b1);
                    end else begin
                        qa.push_back({d1, d2, (i % 3 == 1)});
                        send_a(d1, 1'b0);
                        send_a(d2, (i % 3 == 1));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    a.rready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain_a();
        cnt_chk = 1'b0;

        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
